// File: rtl/usbf_mem_icb_bridge_if.sv
// Bundles the ICB command/response channel and the MEM request/ready signals
// exchanged between the CPU-side ICB slave, this bridge and the synchroniser.
interface usbf_mem_icb_bridge_if #(
  parameter int unsigned EP_NUM   = 4,
  parameter int unsigned EP_IDX_W = 2,
  parameter int unsigned DATA_W   = 8
);
  localparam int unsigned BUS_W = DATA_W * EP_NUM;

  logic                icb_cmd_valid_i;
  logic                icb_cmd_ready_o;
  logic                icb_cmd_read_i;
  logic [EP_IDX_W-1:0] icb_cmd_ep_i;
  logic [DATA_W-1:0]   icb_cmd_wdata_i;
  logic                icb_rsp_valid_o;
  logic                icb_rsp_ready_i;
  logic [DATA_W-1:0]   icb_rsp_rdata_o;
  logic                icb_rsp_err_o;
  logic [EP_NUM-1:0]   ep_data_rd_req_o;
  logic [EP_NUM-1:0]   ep_data_wt_req_o;
  logic [BUS_W-1:0]    ep_tx_data_o;
  logic [BUS_W-1:0]    ep_rx_data_i;
  logic                mem_rd_ready_i;
  logic                mem_wt_ready_i;

  // Bridge side
  modport slave (
    input  icb_cmd_valid_i, icb_cmd_read_i, icb_cmd_ep_i, icb_cmd_wdata_i,
    input  icb_rsp_ready_i, ep_rx_data_i, mem_rd_ready_i, mem_wt_ready_i,
    output icb_cmd_ready_o, icb_rsp_valid_o, icb_rsp_rdata_o, icb_rsp_err_o,
    output ep_data_rd_req_o, ep_data_wt_req_o, ep_tx_data_o
  );

  // CPU / synchroniser side
  modport master (
    output icb_cmd_valid_i, icb_cmd_read_i, icb_cmd_ep_i, icb_cmd_wdata_i,
    output icb_rsp_ready_i, ep_rx_data_i, mem_rd_ready_i, mem_wt_ready_i,
    input  icb_cmd_ready_o, icb_rsp_valid_o, icb_rsp_rdata_o, icb_rsp_err_o,
    input  ep_data_rd_req_o, ep_data_wt_req_o, ep_tx_data_o
  );
endinterface

// File: rtl/usbf_mem_icb_bridge.sv
// hclk-domain bridge: turns ICB endpoint-data accesses into one-cycle MEM
// request pulses, waits for the synchronised ready pulse and answers on ICB.
module usbf_mem_icb_bridge #(
  parameter int unsigned EP_NUM   = 4,
  parameter int unsigned EP_IDX_W = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8
) (
  input logic                  hclk_i,
  input logic                  rstn_i,
  usbf_mem_icb_bridge_if.slave bus
);
  localparam int unsigned BUS_W = DATA_W * EP_NUM;
  localparam int unsigned EPC_W = EP_IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WT_WAIT, S_RSP} state_t;

  state_t              r_state, w_state_nxt;
  logic [EP_IDX_W-1:0] r_ep, w_ep_nxt;
  logic [TO_W-1:0]     r_cnt, w_cnt_nxt;
  logic [EP_NUM-1:0]   r_rd_req, w_rd_req_nxt;
  logic [EP_NUM-1:0]   r_wt_req, w_wt_req_nxt;
  logic [BUS_W-1:0]    r_tx_data, w_tx_data_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_err, w_err_nxt;

  logic [EP_NUM-1:0]   w_cmd_oh;
  logic [DATA_W-1:0]   w_rx_sel;
  logic                w_ep_legal;
  logic                w_expired;

  // Endpoint decode of the incoming command and RX slice of the latched endpoint
  always_comb begin
    w_cmd_oh = '0;
    w_rx_sel = '0;
    for (int unsigned k = 0; k < EP_NUM; k++) begin
      w_cmd_oh[k] = (bus.icb_cmd_ep_i == EP_IDX_W'(k));
      if (r_ep == EP_IDX_W'(k)) w_rx_sel = bus.ep_rx_data_i[k*DATA_W +: DATA_W];
    end
  end

  assign w_ep_legal = ({1'b0, bus.icb_cmd_ep_i} < EPC_W'(EP_NUM));
  assign w_expired  = (r_cnt == TO_W'(TIMEOUT - 1));

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_ep_nxt      = r_ep;
    w_cnt_nxt     = r_cnt;
    w_rd_req_nxt  = '0;
    w_wt_req_nxt  = '0;
    w_tx_data_nxt = r_tx_data;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = r_err;

    unique case (r_state)
      S_IDLE: begin
        if (bus.icb_cmd_valid_i) begin
          w_rdata_nxt = '0;
          if (!w_ep_legal) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_RSP;
          end else begin
            w_err_nxt = 1'b0;
            w_ep_nxt  = bus.icb_cmd_ep_i;
            w_cnt_nxt = '0;
            if (bus.icb_cmd_read_i) begin
              w_rd_req_nxt = w_cmd_oh;
              w_state_nxt  = S_RD_WAIT;
            end else begin
              w_wt_req_nxt = w_cmd_oh;
              for (int unsigned k = 0; k < EP_NUM; k++) begin
                if (w_cmd_oh[k]) w_tx_data_nxt[k*DATA_W +: DATA_W] = bus.icb_cmd_wdata_i;
              end
              w_state_nxt = S_WT_WAIT;
            end
          end
        end
      end
      S_RD_WAIT: begin
        // A ready in the expiry cycle still wins over the timeout
        if (bus.mem_rd_ready_i) begin
          w_rdata_nxt = w_rx_sel;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RSP;
        end else if (w_expired) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RSP;
        end else begin
          w_cnt_nxt = r_cnt + TO_W'(1);
        end
      end
      S_WT_WAIT: begin
        if (bus.mem_wt_ready_i) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RSP;
        end else if (w_expired) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RSP;
        end else begin
          w_cnt_nxt = r_cnt + TO_W'(1);
        end
      end
      S_RSP: begin
        if (bus.icb_rsp_ready_i) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= S_IDLE;
      r_ep      <= '0;
      r_cnt     <= '0;
      r_rd_req  <= '0;
      r_wt_req  <= '0;
      r_tx_data <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ep      <= w_ep_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_req  <= w_rd_req_nxt;
      r_wt_req  <= w_wt_req_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Handshake flags are direct decodes of the state register
  assign bus.icb_cmd_ready_o  = (r_state == S_IDLE);
  assign bus.icb_rsp_valid_o  = (r_state == S_RSP);
  assign bus.icb_rsp_rdata_o  = r_rdata;
  assign bus.icb_rsp_err_o    = r_err;
  assign bus.ep_data_rd_req_o = r_rd_req;
  assign bus.ep_data_wt_req_o = r_wt_req;
  assign bus.ep_tx_data_o     = r_tx_data;

endmodule

// File: tb/tb_usbf_mem_icb_bridge.sv
// Directed bench for usbf_mem_icb_bridge with a 3-bit endpoint field so that
// out-of-range endpoint indices can be driven.
module tb_usbf_mem_icb_bridge;
  localparam int unsigned EP_NUM   = 4;
  localparam int unsigned EP_IDX_W = 3;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned TIMEOUT  = 255;
  localparam int unsigned TO_W     = 8;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_failed;
  int   early;

  usbf_mem_icb_bridge_if #(.EP_NUM(EP_NUM), .EP_IDX_W(EP_IDX_W), .DATA_W(DATA_W)) bus ();

  usbf_mem_icb_bridge #(
    .EP_NUM(EP_NUM), .EP_IDX_W(EP_IDX_W), .DATA_W(DATA_W),
    .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .hclk_i(clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rsp_handshake();
    bus.icb_rsp_ready_i = 1'b1;
    tick();
    bus.icb_rsp_ready_i = 1'b0;
  endtask

  task automatic issue(input logic rd, input logic [2:0] ep, input logic [7:0] wd);
    bus.icb_cmd_valid_i = 1'b1;
    bus.icb_cmd_read_i  = rd;
    bus.icb_cmd_ep_i    = ep;
    bus.icb_cmd_wdata_i = wd;
    tick();
    bus.icb_cmd_valid_i = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rstn = 1'b0;
    bus.icb_cmd_valid_i = 1'b0;
    bus.icb_cmd_read_i  = 1'b0;
    bus.icb_cmd_ep_i    = '0;
    bus.icb_cmd_wdata_i = '0;
    bus.icb_rsp_ready_i = 1'b0;
    bus.ep_rx_data_i    = 32'h44_3C_22_11;
    bus.mem_rd_ready_i  = 1'b0;
    bus.mem_wt_ready_i  = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Reset state
    chk("rst_cmd_ready", 32'(bus.icb_cmd_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(bus.icb_rsp_valid_o), 32'd0);
    chk("rst_rd_req",    32'(bus.ep_data_rd_req_o), 32'd0);
    chk("rst_wt_req",    32'(bus.ep_data_wt_req_o), 32'd0);
    chk("rst_tx_data",   bus.ep_tx_data_o, 32'h0);
    chk("rst_rdata",     32'(bus.icb_rsp_rdata_o), 32'd0);
    chk("rst_err",       32'(bus.icb_rsp_err_o), 32'd0);

    // 1: write ep1 0xA5, ready 6 cycles after accept
    issue(1'b0, 3'd1, 8'hA5);
    chk("w1_wt_req",    32'(bus.ep_data_wt_req_o), 32'h2);
    chk("w1_rd_req",    32'(bus.ep_data_rd_req_o), 32'h0);
    chk("w1_tx_data",   bus.ep_tx_data_o, 32'h0000_A500);
    chk("w1_cmd_ready", 32'(bus.icb_cmd_ready_o), 32'd0);
    tick();
    chk("w1_wt_req_one", 32'(bus.ep_data_wt_req_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("w1_no_rsp", 32'(bus.icb_rsp_valid_o), 32'd0);
    end
    bus.mem_wt_ready_i = 1'b1;
    tick();
    bus.mem_wt_ready_i = 1'b0;
    chk("w1_rsp_valid", 32'(bus.icb_rsp_valid_o), 32'd1);
    chk("w1_rsp_err",   32'(bus.icb_rsp_err_o), 32'd0);
    chk("w1_rsp_rdata", 32'(bus.icb_rsp_rdata_o), 32'd0);
    rsp_handshake();
    chk("w1_idle",      32'(bus.icb_cmd_ready_o), 32'd1);
    chk("w1_rsp_done",  32'(bus.icb_rsp_valid_o), 32'd0);

    // 2: read ep2, stray write-ready ignored in RD_WAIT
    issue(1'b1, 3'd2, 8'h00);
    chk("r2_rd_req", 32'(bus.ep_data_rd_req_o), 32'h4);
    chk("r2_wt_req", 32'(bus.ep_data_wt_req_o), 32'h0);
    bus.mem_wt_ready_i = 1'b1;
    tick();
    bus.mem_wt_ready_i = 1'b0;
    chk("r2_rd_req_one",  32'(bus.ep_data_rd_req_o), 32'h0);
    chk("r2_wt_ignored",  32'(bus.icb_rsp_valid_o), 32'd0);
    bus.mem_rd_ready_i = 1'b1;
    tick();
    bus.mem_rd_ready_i = 1'b0;
    chk("r2_rsp_valid", 32'(bus.icb_rsp_valid_o), 32'd1);
    chk("r2_rsp_rdata", 32'(bus.icb_rsp_rdata_o), 32'h3C);
    chk("r2_rsp_err",   32'(bus.icb_rsp_err_o), 32'd0);
    rsp_handshake();

    // 3: read ep0 with no ready -> error exactly 255 cycles after the pulse
    issue(1'b1, 3'd0, 8'h00);
    chk("t3_rd_req", 32'(bus.ep_data_rd_req_o), 32'h1);
    early = 0;
    for (int i = 1; i < 255; i++) begin
      tick();
      if (bus.icb_rsp_valid_o) early++;
    end
    chk("t3_not_early", 32'(early), 32'd0);
    tick();
    chk("t3_rsp_valid", 32'(bus.icb_rsp_valid_o), 32'd1);
    chk("t3_rsp_err",   32'(bus.icb_rsp_err_o), 32'd1);
    chk("t3_rsp_rdata", 32'(bus.icb_rsp_rdata_o), 32'd0);
    rsp_handshake();
    // Stale ready in IDLE is discarded
    bus.mem_rd_ready_i = 1'b1;
    tick();
    bus.mem_rd_ready_i = 1'b0;
    chk("t3_stale_idle", 32'(bus.icb_cmd_ready_o), 32'd1);
    chk("t3_stale_rsp",  32'(bus.icb_rsp_valid_o), 32'd0);

    // 4: illegal endpoint 4 -> immediate error, no pulse, tx unchanged
    issue(1'b0, 3'd4, 8'hFF);
    chk("i4_rsp_valid", 32'(bus.icb_rsp_valid_o), 32'd1);
    chk("i4_rsp_err",   32'(bus.icb_rsp_err_o), 32'd1);
    chk("i4_rsp_rdata", 32'(bus.icb_rsp_rdata_o), 32'd0);
    chk("i4_wt_req",    32'(bus.ep_data_wt_req_o), 32'h0);
    chk("i4_rd_req",    32'(bus.ep_data_rd_req_o), 32'h0);
    chk("i4_tx_data",   bus.ep_tx_data_o, 32'h0000_A500);
    rsp_handshake();

    // Highest legal endpoint; read-ready ignored in WT_WAIT
    issue(1'b0, 3'd3, 8'h5A);
    chk("b3_wt_req",  32'(bus.ep_data_wt_req_o), 32'h8);
    chk("b3_tx_data", bus.ep_tx_data_o, 32'h5A00_A500);
    bus.mem_rd_ready_i = 1'b1;
    tick();
    bus.mem_rd_ready_i = 1'b0;
    chk("b3_rd_ignored", 32'(bus.icb_rsp_valid_o), 32'd0);
    bus.mem_wt_ready_i = 1'b1;
    tick();
    bus.mem_wt_ready_i = 1'b0;
    chk("b3_rsp_valid", 32'(bus.icb_rsp_valid_o), 32'd1);
    chk("b3_rsp_err",   32'(bus.icb_rsp_err_o), 32'd0);
    rsp_handshake();

    // 5: response back-pressure with a pending command
    issue(1'b1, 3'd1, 8'h00);
    bus.mem_rd_ready_i = 1'b1;
    tick();
    bus.mem_rd_ready_i = 1'b0;
    bus.icb_cmd_valid_i = 1'b1;
    bus.icb_cmd_read_i  = 1'b0;
    bus.icb_cmd_ep_i    = 3'd0;
    bus.icb_cmd_wdata_i = 8'h77;
    for (int i = 0; i < 10; i++) begin
      chk("s5_rsp_valid", 32'(bus.icb_rsp_valid_o), 32'd1);
      chk("s5_rsp_rdata", 32'(bus.icb_rsp_rdata_o), 32'h22);
      chk("s5_rsp_err",   32'(bus.icb_rsp_err_o), 32'd0);
      chk("s5_cmd_ready", 32'(bus.icb_cmd_ready_o), 32'd0);
      chk("s5_no_pulse",  32'(bus.ep_data_rd_req_o | bus.ep_data_wt_req_o), 32'h0);
      tick();
    end
    bus.icb_rsp_ready_i = 1'b1;
    tick();
    bus.icb_rsp_ready_i = 1'b0;
    chk("s5_after_hs_ready", 32'(bus.icb_cmd_ready_o), 32'd1);
    chk("s5_after_hs_pulse", 32'(bus.ep_data_wt_req_o), 32'h0);
    chk("s5_after_hs_tx",    bus.ep_tx_data_o, 32'h5A00_A500);
    tick();
    bus.icb_cmd_valid_i = 1'b0;
    chk("s5_accept_pulse", 32'(bus.ep_data_wt_req_o), 32'h1);
    chk("s5_accept_tx",    bus.ep_tx_data_o, 32'h5A00_A577);

    // 6: asynchronous reset in WT_WAIT; late ready ignored
    rstn = 1'b0;
    #1;
    chk("r6_cmd_ready", 32'(bus.icb_cmd_ready_o), 32'd1);
    chk("r6_wt_req",    32'(bus.ep_data_wt_req_o), 32'h0);
    chk("r6_tx_data",   bus.ep_tx_data_o, 32'h0);
    chk("r6_rsp_valid", 32'(bus.icb_rsp_valid_o), 32'd0);
    tick();
    rstn = 1'b1;
    bus.mem_wt_ready_i = 1'b1;
    tick();
    bus.mem_wt_ready_i = 1'b0;
    chk("r6_late_rsp",   32'(bus.icb_rsp_valid_o), 32'd0);
    chk("r6_late_ready", 32'(bus.icb_cmd_ready_o), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end
endmodule
